spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Shares one SPI master byte engine between `NUM_REQUESTERS` requesters (e.g. CPU-side SPI peripheral and a DMA or flash-boot sequencer) in the RVX SoC. Round-robin arbitration at transaction granularity. A granted requester keeps the engine and its chip-select asserted until it sends a byte flagged `last`. The block sequences each byte as a start/done handshake to the master and returns the received byte with a one-cycle acknowledge.

## Interface

Parameters:
- `NUM_REQUESTERS`, 2: number of requesters, 2..8.
- `SPI_NUM_CHIP_SELECT`, 1: chip-select lines driven by the master.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQUESTERS  per-requester byte request, level.
- `req_last`  in  NUM_REQUESTERS  current byte ends the requester's transaction.
- `req_tx_data`  in  8*NUM_REQUESTERS  byte to send; requester i at bits [8i+7:8i].
- `req_cs`  in  SPI_NUM_CHIP_SELECT*NUM_REQUESTERS  one-hot chip-select mask per requester.
- `grant`  out  NUM_REQUESTERS  one-hot owner; all zero when idle.
- `ack`  out  NUM_REQUESTERS  one-cycle pulse to the owner when its byte completes.
- `rx_data`  out  8  received byte, valid in the `ack` cycle, held until the next `ack`.
- `m_start`  out  1  one-cycle pulse starting a byte transfer.
- `m_tx_data`  out  8  byte for the master.
- `m_cs`  out  SPI_NUM_CHIP_SELECT  chip-select mask for the master.
- `m_cs_hold`  out  1  keep CS asserted after this byte.
- `m_done`  in  1  one-cycle pulse from the master at byte end.
- `m_rx_data`  in  8  byte received by the master, valid with `m_done`.

## Operation

- States: IDLE, GRANT, START, WAIT, ACK.
- IDLE: when any `req` bit is high, choose a winner by round-robin. The search starts at `rr_ptr+1` modulo NUM_REQUESTERS. Register `owner`, set `rr_ptr <= owner`, latch `m_cs <= req_cs[owner]`, clear `started`, and go to GRANT.
- GRANT: sample `req[owner]`.
  - If high: latch `m_tx_data <= req_tx_data[owner]`, set `m_cs_hold <= !req_last[owner]`, latch `last_q`, and go to START.
  - If low and `started == 0`, the requester withdrew: go to IDLE.
  - If low and `started == 1`, the transaction is open: stay in GRANT. Ownership and `m_cs_hold = 1` are kept indefinitely.
- START: `m_start = 1` for exactly one cycle. Set `started`, then go to WAIT.
- WAIT: on `m_done`, register `rx_data <= m_rx_data` and go to ACK. Otherwise stay in WAIT; there is no timeout.
- ACK: `ack[owner] = 1` for one cycle. If `last_q`, go to IDLE, which releases the bus. Otherwise go to GRANT.
- `grant[owner]` is high in GRANT, START, WAIT and ACK. It is low in IDLE.
- `m_tx_data`, `m_cs` and `m_cs_hold` are registered and stable from START until the next GRANT update.
- `m_done` is ignored in every state except WAIT.
- Requests from non-owners are ignored while the bus is owned; they are not queued beyond their level.
- Reset (asynchronous): state IDLE, `grant = 0`, `ack = 0`, `m_start = 0`, `m_tx_data = 0`, `m_cs = 0`, `m_cs_hold = 0`, `rx_data = 0`, `rr_ptr = NUM_REQUESTERS-1` (requester 0 wins first), `started = 0`.
- Reset mid-transfer aborts immediately. The master is responsible for its own reset.

## Timing

- `req` high at edge k while IDLE: `grant` high from k+1, `m_start` high in cycle k+2.
- `m_done` in cycle d: `ack` and `rx_data` valid in cycle d+1.
- The requester updates `req`, `req_tx_data` and `req_last` at the edge ending its `ack` cycle. GRANT samples them one cycle later.
- Back-to-back bytes in one transaction: `m_start` occurs 2 cycles after `ack`, i.e. 3 cycles after `m_done`.
- Release: after the `last` byte's ACK cycle, state is IDLE. A new winner is granted 1 cycle later, so `grant` is low for exactly 1 cycle between owners.
- Latency is independent of NUM_REQUESTERS. Round-robin selection is combinational in IDLE.

## Test plan

- Single requester: `req[0] = 1`, 3 bytes 0xA5, 0x3C, 0x81 (`last` on the third); master echoes ~tx. Expect 3 `m_start` pulses with `m_cs_hold` = 1,1,0; `ack[0]` ×3; `rx_data` = 0x5A, 0xC3, 0x7E; `grant` low after the final ACK.
- Contention: `req[0]` and `req[1]` high together from reset. Expect requester 0 granted first and requester 1 granted after 0's last byte, with a 1-cycle grant gap. Then with both re-requesting, expect 0 granted again (round-robin alternation over 4 transactions: 0, 1, 0, 1).
- Lock: requester 1 owns the bus and drops `req` after a non-last byte while `req[0]` is high. Expect the state to stay in GRANT, `grant[1]` held, `m_cs_hold = 1`, and no grant to 0 until 1 completes a `last` byte.
- Withdrawal: `req[1]` pulses for 1 cycle in IDLE, then goes low. Expect grant then return to IDLE with no `m_start`, and `rr_ptr = 1`.
- Spurious and slow done: `m_done` pulsed in IDLE and GRANT has no effect. In WAIT, `m_done` delayed 50 cycles: `m_start` stays single-pulse and `ack` comes 1 cycle after `m_done`.
- Reset mid-transfer: assert `reset` low in WAIT. All outputs go to 0 asynchronously; after release, requester 0 wins first.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master byte engine among requesters.
// Ownership lasts a whole transaction, i.e. until a byte flagged last completes.
module spi_bus_arbiter #(
    parameter int NUM_REQUESTERS      = 2,
    parameter int SPI_NUM_CHIP_SELECT = 1
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUM_REQUESTERS-1:0]                     req,
    input  logic [NUM_REQUESTERS-1:0]                     req_last,
    input  logic [8*NUM_REQUESTERS-1:0]                   req_tx_data,
    input  logic [SPI_NUM_CHIP_SELECT*NUM_REQUESTERS-1:0] req_cs,
    output logic [NUM_REQUESTERS-1:0]                     grant,
    output logic [NUM_REQUESTERS-1:0]                     ack,
    output logic [7:0]                                    rx_data,
    output logic                                          m_start,
    output logic [7:0]                                    m_tx_data,
    output logic [SPI_NUM_CHIP_SELECT-1:0]                m_cs,
    output logic                                          m_cs_hold,
    input  logic                                          m_done,
    input  logic [7:0]                                    m_rx_data
);

    localparam int IW = $clog2(NUM_REQUESTERS);
    localparam int CSW = SPI_NUM_CHIP_SELECT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          any_req;
    logic          started;
    logic          last_q;

    logic [7:0]     tx_arr [NUM_REQUESTERS];
    logic [CSW-1:0] cs_arr [NUM_REQUESTERS];

    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            tx_arr[i] = req_tx_data[8*i +: 8];
            cs_arr[i] = req_cs[CSW*i +: CSW];
        end
    end

    // Walk offsets from far to near so the nearest requester after rr_ptr wins.
    always_comb begin
        winner  = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = NUM_REQUESTERS; i >= 1; i--) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_REQUESTERS);
            if (req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_req) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (req[owner])   state_nxt = ST_START;
                else if (!started) state_nxt = ST_IDLE;
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (m_done) state_nxt = ST_ACK;
            end
            ST_ACK: state_nxt = last_q ? ST_IDLE : ST_GRANT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= IW'(NUM_REQUESTERS - 1);
            started   <= 1'b0;
            last_q    <= 1'b0;
            m_tx_data <= '0;
            m_cs      <= '0;
            m_cs_hold <= 1'b0;
            rx_data   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        rr_ptr  <= winner;
                        m_cs    <= cs_arr[winner];
                        started <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (req[owner]) begin
                        m_tx_data <= tx_arr[owner];
                        m_cs_hold <= !req_last[owner];
                        last_q    <= req_last[owner];
                    end
                end
                ST_START: started <= 1'b1;
                ST_WAIT: begin
                    if (m_done) rx_data <= m_rx_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        ack   = '0;
        if (state != ST_IDLE) grant[owner] = 1'b1;
        if (state == ST_ACK)  ack[owner]   = 1'b1;
    end

    assign m_start = (state == ST_START);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios, then randomized
// requesters and master checked against a transaction-level model.
module tb_spi_bus_arbiter;

    localparam int N   = 3;
    localparam int CSW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_last;
    logic [8*N-1:0]   req_tx_data;
    logic [CSW*N-1:0] req_cs;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic [7:0]       rx_data;
    logic             m_start;
    logic [7:0]       m_tx_data;
    logic [CSW-1:0]   m_cs;
    logic             m_cs_hold;
    logic             m_done = 1'b0;
    logic [7:0]       m_rx_data = '0;

    always #5 clock = ~clock;

    spi_bus_arbiter #(
        .NUM_REQUESTERS(N),
        .SPI_NUM_CHIP_SELECT(CSW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .req_last(req_last),
        .req_tx_data(req_tx_data),
        .req_cs(req_cs),
        .grant(grant),
        .ack(ack),
        .rx_data(rx_data),
        .m_start(m_start),
        .m_tx_data(m_tx_data),
        .m_cs(m_cs),
        .m_cs_hold(m_cs_hold),
        .m_done(m_done),
        .m_rx_data(m_rx_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    // requester-side model
    bit             act [N];
    int             rem [N];
    logic [7:0]     cur [N];
    logic [CSW-1:0] csm [N];
    int             gap [N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_tx_data[8*i +: 8]   = cur[i];
            req_cs[CSW*i +: CSW]    = csm[i];
            req_last[i]             = (rem[i] == 1);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            act[i] = 0;
            rem[i] = 0;
            cur[i] = '0;
            csm[i] = CSW'(1);
            gap[i] = 0;
        end
        req    = '0;
        m_done = 1'b0;
        drive_reqs();
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int o);
        return N'(1) << o;
    endfunction

    int         slow_cnt;
    int         gst;
    int         owner;
    int         rr;
    int         due;
    int         p;
    int         dcnt;
    bit         ack_due;
    bit         busy;
    bit         seen_start;
    logic [7:0] exp_rx;
    logic [7:0] last_rx;
    logic [7:0] tx_cap;
    logic [7:0] byte_exp;

    initial begin
        clear_model();
        #23;
        @(negedge clock) reset = 1'b1;

        // done while idle is ignored
        m_done    = 1'b1;
        m_rx_data = 8'hFF;
        tick();
        m_done = 1'b0;
        chk("spur_idle", {grant, ack, rx_data}, 0);

        // withdrawal: grant then back to idle with no start
        req = 3'b010;
        tick();
        chk("wd_grant", {grant, m_start}, {3'b010, 1'b0});
        req = 3'b000;
        tick();
        chk("wd_release", {grant, m_start}, 0);
        for (int i = 0; i < N; i++) begin
            rem[i] = 1;
            cur[i] = 8'hA0 + 8'(i);
        end
        drive_reqs();
        req = 3'b111;
        tick();
        chk("wd_rr", grant, 3'b100);
        tick();
        chk("wd_start", {m_start, m_tx_data, m_cs_hold}, {1'b1, 8'hA2, 1'b0});

        // slow done: one start, no ack until done
        slow_cnt = 0;
        repeat (50) begin
            tick();
            slow_cnt += int'(m_start) + int'(ack != 0);
        end
        chk("slow_quiet", slow_cnt, 0);
        m_done    = 1'b1;
        m_rx_data = 8'h3C;
        tick();
        m_done = 1'b0;
        chk("slow_ack", {ack, rx_data}, {3'b100, 8'h3C});
        req = '0;
        tick();
        chk("slow_release", grant, 0);

        // lock: owner 1 drops req mid-transaction
        rem[1] = 2;
        cur[1] = 8'h11;
        csm[1] = 2'b10;
        rem[0] = 1;
        cur[0] = 8'h44;
        drive_reqs();
        req = 3'b010;
        tick();
        chk("lock_grant", grant, 3'b010);
        req = 3'b011;
        tick();
        chk("lock_start", {m_start, m_tx_data, m_cs, m_cs_hold},
            {1'b1, 8'h11, 2'b10, 1'b1});
        tick();
        m_done    = 1'b1;
        m_rx_data = 8'h5A;
        tick();
        m_done = 1'b0;
        chk("lock_ack", {ack, rx_data}, {3'b010, 8'h5A});
        req[1] = 1'b0;
        cur[1] = 8'h22;
        rem[1] = 1;
        drive_reqs();
        repeat (5) begin
            tick();
            chk("lock_hold", {grant, m_cs_hold, m_start}, {3'b010, 1'b1, 1'b0});
        end
        req[1] = 1'b1;
        tick();
        chk("lock_last", {m_start, m_tx_data, m_cs_hold}, {1'b1, 8'h22, 1'b0});
        tick();
        m_done    = 1'b1;
        m_rx_data = 8'h99;
        tick();
        m_done = 1'b0;
        req[1] = 1'b0;
        chk("lock_ack2", {ack, rx_data}, {3'b010, 8'h99});
        tick();
        chk("lock_gap", grant, 0);
        tick();
        chk("lock_next", grant, 3'b001);

        // asynchronous reset in WAIT
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rst_async", {grant, ack, m_start, m_tx_data, m_cs, m_cs_hold, rx_data}, 0);
        req = 3'b011;
        @(negedge clock) reset = 1'b1;
        tick();
        chk("rst_rr", grant, 3'b001);

        // randomized phase
        reset = 1'b0;
        clear_model();
        #7;
        @(negedge clock) reset = 1'b1;
        gst     = 2;
        owner   = 0;
        rr      = N - 1;
        due     = 0;
        ack_due = 0;
        busy    = 0;
        dcnt    = 0;
        exp_rx  = '0;
        last_rx = '0;
        tx_cap  = '0;
        byte_exp = '0;
        repeat (3000) begin
            tick();
            seen_start = m_start;
            chk("start_timing", m_start, due == 1);
            if (due > 0) due--;
            if (m_start) begin
                chk("start_data", {m_tx_data, m_cs, m_cs_hold},
                    {cur[owner], csm[owner], rem[owner] != 1});
                busy     = 1;
                dcnt     = $urandom_range(1, 4);
                tx_cap   = m_tx_data;
                byte_exp = cur[owner];
            end

            if (gst == 2) begin
                p = (req != 0) ? pick(req, rr) : -1;
                chk("grant_pick", grant, (p >= 0) ? onehot(p) : '0);
                if (p >= 0) begin
                    owner = p;
                    rr    = p;
                    gst   = 0;
                    due   = 1;
                end
            end else if (gst == 1) begin
                chk("grant_gap", grant, 0);
                gst = 2;
            end else begin
                chk("grant_hold", grant, onehot(owner));
            end

            if (gst == 0 && gap[owner] > 0) begin
                chk("lock_cs_hold", m_cs_hold, 1);
                gap[owner]--;
                if (gap[owner] == 0) begin
                    req[owner] = 1'b1;
                    due        = 1;
                end
            end

            if (ack_due) begin
                chk("ack", {ack, rx_data}, {onehot(owner), exp_rx});
                last_rx = exp_rx;
                ack_due = 0;
                rem[owner]--;
                if (rem[owner] == 0) begin
                    act[owner] = 0;
                    req[owner] = 1'b0;
                    gst        = 1;
                end else begin
                    cur[owner] = 8'($urandom);
                    if ($urandom_range(0, 2) == 0) begin
                        gap[owner] = $urandom_range(1, 3);
                        req[owner] = 1'b0;
                    end else begin
                        due = 2;
                    end
                end
            end else begin
                chk("ack_quiet", {ack, rx_data}, {3'b000, last_rx});
            end

            m_done = 1'b0;
            if (busy && !seen_start) begin
                dcnt--;
                if (dcnt == 0) begin
                    m_done    = 1'b1;
                    m_rx_data = ~tx_cap;
                    exp_rx    = ~byte_exp;
                    busy      = 0;
                    ack_due   = 1;
                end
            end else if (!busy && $urandom_range(0, 7) == 0) begin
                m_done    = 1'b1;
                m_rx_data = 8'($urandom);
            end

            for (int i = 0; i < N; i++) begin
                if (!act[i] && $urandom_range(0, 4) == 0) begin
                    act[i] = 1;
                    rem[i] = $urandom_range(1, 4);
                    cur[i] = 8'($urandom);
                    csm[i] = CSW'(1) << $urandom_range(0, CSW - 1);
                    req[i] = 1'b1;
                end
            end
            drive_reqs();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
